systolic_skew_feeder: RTL and testbench
=======================================

Name: systolic_skew_feeder

Overview:
- Top-edge driver for the weight-stationary systolic array.
- Accepts one activation vector per cycle over a valid/ready stream and presents it to the array's column inputs with diagonal skew: column c is delayed c cycles relative to column 0, so partial sums meet their operands in each row.
- After the last vector of a burst, it drains the skew pipeline with zeros; the array PEs are free-running, so bubbles must be zero.

Parameters:
- DATA_WIDTH, 16, width of one activation element (matches PE top_in).
- COLS, 4, number of array columns; must be >= 1.
- CNT_WIDTH, 16, width of the accepted-vector counter.

Ports:
- clk  input  1  clock.
- aresetn  input  1  reset, asynchronous, active-low.
- s_valid  input  1  input vector valid.
- s_ready  output  1  feeder can accept a vector this cycle.
- s_data  input  COLS*DATA_WIDTH  vector; element c at bits [c*DATA_WIDTH +: DATA_WIDTH].
- s_last  input  1  marks the final vector of a burst; qualified by s_valid.
- top_out  output  COLS*DATA_WIDTH  skewed column data to the array top edge, same packing.
- col_valid  output  COLS  bit c is high when top_out element c carries a real element.
- busy  output  1  high in STREAM or FLUSH.
- done  output  1  one-cycle pulse when FLUSH completes.
- vec_count  output  CNT_WIDTH  vectors accepted in the current burst.

Behaviour:
- Reset: all outputs are 0 except s_ready. s_ready = 1 once aresetn deasserts. All delay stages clear to 0. FSM enters IDLE.
- Transfer: occurs on a rising edge with s_valid && s_ready.
- FSM states:
  - IDLE: s_ready=1, busy=0. Transfer with s_last=0 -> STREAM. Transfer with s_last=1 -> FLUSH (or straight to IDLE with done if COLS==1).
  - STREAM: s_ready=1, busy=1. Transfer with s_last=1 -> FLUSH (COLS==1: -> IDLE, done). Otherwise stay.
  - FLUSH: s_ready=0, busy=1. A down-counter is loaded with COLS-1 on entry. It decrements each cycle. Leaving FLUSH at count 0 -> IDLE, with done high for exactly the first IDLE cycle.
- Skew and latency:
  - Each column has a registered delay line of depth c+1, carrying data plus a valid bit.
  - A vector accepted at edge k drives element c on top_out with col_valid[c]=1 during the cycle after edge k+c.
  - Column 0 latency is 1 cycle; column COLS-1 latency is COLS cycles.
- Bubbles: on any edge without a transfer (including FLUSH and IDLE), stage 0 of every column loads data 0 with valid 0. A non-valid top_out element is always 0.
- FLUSH length: COLS-1 cycles is exactly enough for the last vector's column COLS-1 element to appear. That element is presented in the same cycle done is high.
- vec_count:
  - Increments on each transfer; wraps modulo 2^CNT_WIDTH.
  - Cleared to 0 on a transfer that starts a new burst from IDLE, then counts that transfer, so it reads 1 afterward.
  - Holds its value through FLUSH and IDLE until the next burst.
- Input stability: s_valid may be held high during FLUSH. Nothing is accepted until IDLE, and upstream must hold s_data and s_last stable.
- Reset mid-operation: asynchronous clear of the FSM, counters and all delay stages. No done pulse is generated.
- No arithmetic is performed; data passes bit-exact.

Decomposition:
- Shared package systolic_pkg holds:
  - default DATA_WIDTH and COLS constants;
  - the feeder state enum (IDLE, STREAM, FLUSH);
  - an element-slice helper function for packed column vectors.
- One sub-module, skew_delay_line (parameters DEPTH, WIDTH): a reset-clearing shift register carrying {valid, data}. It is instantiated once per column with DEPTH = c+1.

Test Plan:
- Reset -> after aresetn rises: s_ready=1, busy=0, done=0, vec_count=0, top_out=0, col_valid=0.
- COLS=4, single vector {4,3,2,1} (col0=1) with s_last at edge k -> col0=1 after edge k, col1=2 after k+1, col2=3 after k+2, col3=4 after k+3. s_ready=0 for 3 cycles. done pulses with col3=4. vec_count=1.
- Three back-to-back vectors A,B,C (C last), then s_valid held high with D during FLUSH -> each column shows A,B,C on consecutive cycles. D is not accepted until the IDLE cycle. D's transfer resets vec_count, which then reads 1.
- Burst with bubble: A, idle cycle, B(last) -> each column shows A, 0 (col_valid 0), B, with skew preserved.
- Assert aresetn low mid-FLUSH -> all outputs 0 immediately. No done pulse. Next vector after release behaves as in the single-vector scenario.
- COLS=1 build: vector 7 with s_last -> top_out=7 after edge k, done pulses in that cycle, s_ready never drops.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array edge logic.
package systolic_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 16;
  localparam int unsigned DEFAULT_COLS       = 4;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH
  } feeder_state_t;

  // LSB position of element col in a packed column vector of width-bit elements.
  function automatic int unsigned elem_lsb(input int unsigned col, input int unsigned width);
    return col * width;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Reset-clearing shift register of DEPTH stages carrying {valid, data}.
module skew_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 17
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Top-edge feeder: accepts activation vectors and presents them diagonally skewed.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned COLS       = DEFAULT_COLS,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       aresetn,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [COLS*DATA_WIDTH-1:0] s_data,
  input  logic                       s_last,
  output logic [COLS*DATA_WIDTH-1:0] top_out,
  output logic [COLS-1:0]            col_valid,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_WIDTH-1:0]       vec_count
);

  localparam int unsigned FW = (COLS > 1) ? $clog2(COLS) : 1;

  feeder_state_t state, state_nxt;
  logic [FW-1:0] flush_cnt;
  logic          xfer;
  logic          flush_end;
  logic          done_nxt;

  assign xfer = s_valid && s_ready;
  // Counter is loaded with COLS-1 and FLUSH exits on the edge that takes it to 0.
  assign flush_end = (state == FLUSH) && (flush_cnt == FW'(1));

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      flush_cnt <= '0;
      done      <= 1'b0;
      vec_count <= '0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      if (state != FLUSH && state_nxt == FLUSH) flush_cnt <= FW'(COLS - 1);
      else if (state == FLUSH)                  flush_cnt <= flush_cnt - 1'b1;
      if (xfer) vec_count <= (state == IDLE) ? CNT_WIDTH'(1) : vec_count + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE, STREAM: begin
        if (xfer && s_last) begin
          if (COLS == 1) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = FLUSH;
          end
        end else if (xfer) begin
          state_nxt = STREAM;
        end
      end
      FLUSH: begin
        if (flush_end) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_ready = 1'b1;
    busy    = 1'b0;
    case (state)
      STREAM:  busy = 1'b1;
      FLUSH: begin
        s_ready = 1'b0;
        busy    = 1'b1;
      end
      default: ;
    endcase
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic [DATA_WIDTH:0] d_in;
    logic [DATA_WIDTH:0] d_out;

    assign d_in = xfer ? {1'b1, s_data[elem_lsb(c, DATA_WIDTH) +: DATA_WIDTH]} : '0;

    skew_delay_line #(
      .DEPTH(c + 1),
      .WIDTH(DATA_WIDTH + 1)
    ) u_delay (
      .clk    (clk),
      .aresetn(aresetn),
      .d      (d_in),
      .q      (d_out)
    );

    assign top_out[elem_lsb(c, DATA_WIDTH) +: DATA_WIDTH] = d_out[DATA_WIDTH-1:0];
    assign col_valid[c] = d_out[DATA_WIDTH];
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder (COLS=4 and COLS=1 builds).
module tb_systolic_skew_feeder;

  logic        clk = 1'b0;
  logic        aresetn;

  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [63:0] s_data = '0;
  logic        s_last = 1'b0;
  logic [63:0] top_out;
  logic [3:0]  col_valid;
  logic        busy;
  logic        done;
  logic [15:0] vec_count;

  logic        s1_valid = 1'b0;
  logic        s1_ready;
  logic [15:0] s1_data = '0;
  logic        s1_last = 1'b0;
  logic [15:0] top_out1;
  logic [0:0]  col_valid1;
  logic        busy1;
  logic        done1;
  logic [15:0] vec_count1;

  int total = 0;
  int bad   = 0;

  // Expected outputs for upcoming cycles: [63:0] data, [67:64] valid.
  logic [67:0] exp_q [$];
  int          m_flush = 0;
  logic        m_busy  = 1'b0;
  logic        m_done  = 1'b0;
  logic [15:0] m_vec   = '0;

  always #5 clk = ~clk;

  systolic_skew_feeder #(.DATA_WIDTH(16), .COLS(4), .CNT_WIDTH(16)) u_dut4 (
    .clk(clk), .aresetn(aresetn), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .top_out(top_out), .col_valid(col_valid),
    .busy(busy), .done(done), .vec_count(vec_count)
  );

  systolic_skew_feeder #(.DATA_WIDTH(16), .COLS(1), .CNT_WIDTH(16)) u_dut1 (
    .clk(clk), .aresetn(aresetn), .s_valid(s1_valid), .s_ready(s1_ready),
    .s_data(s1_data), .s_last(s1_last), .top_out(top_out1), .col_valid(col_valid1),
    .busy(busy1), .done(done1), .vec_count(vec_count1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    logic        xfer;
    logic        lst;
    logic        nd;
    logic [63:0] d;
    logic [67:0] e;
    logic [67:0] ex;
    xfer = s_valid && (m_flush == 0);
    lst  = s_last;
    d    = s_data;
    nd   = 1'b0;
    @(posedge clk);
    while (exp_q.size() < 4) exp_q.push_back('0);
    if (xfer) begin
      for (int c = 0; c < 4; c++) begin
        e = exp_q[c];
        e[c*16 +: 16] = d[c*16 +: 16];
        e[64 + c]     = 1'b1;
        exp_q[c]      = e;
      end
    end
    ex = exp_q.pop_front();
    if (m_flush != 0) begin
      m_flush--;
      if (m_flush == 0) begin
        nd     = 1'b1;
        m_busy = 1'b0;
      end
    end else if (xfer) begin
      m_vec  = m_busy ? m_vec + 16'd1 : 16'd1;
      m_busy = 1'b1;
      if (lst) m_flush = 3;
    end
    m_done = nd;
    #1;
    check("top_out",   top_out,   ex[63:0]);
    check("col_valid", col_valid, {60'd0, ex[67:64]});
    check("s_ready",   s_ready,   m_flush == 0);
    check("busy",      busy,      m_busy);
    check("done",      done,      m_done);
    check("vec_count", vec_count, m_vec);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    #1;
    check("rst_top_out",   top_out,   '0);
    check("rst_col_valid", col_valid, '0);
    check("rst_busy",      busy,      1'b0);
    check("rst_done",      done,      1'b0);
    check("rst_vec_count", vec_count, '0);
    check("rst_s_ready",   s_ready,   1'b1);
    check("rst1_top_out",  top_out1,  '0);
    check("rst1_s_ready",  s1_ready,  1'b1);
    exp_q.delete();
    m_flush = 0;
    m_busy  = 1'b0;
    m_done  = 1'b0;
    m_vec   = '0;
    @(negedge clk);
    aresetn = 1'b1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic l);
    s_valid = v;
    s_data  = d;
    s_last  = l;
  endtask

  initial begin
    aresetn = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    // Single vector with last
    drive(1'b1, {16'd4, 16'd3, 16'd2, 16'd1}, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0);
    repeat (5) tick();

    // A, B, C back to back; D held valid through FLUSH
    drive(1'b1, 64'h000A_000A_000A_000A, 1'b0); tick();
    drive(1'b1, 64'h000B_000B_000B_000B, 1'b0); tick();
    drive(1'b1, 64'h000C_000C_000C_000C, 1'b1); tick();
    drive(1'b1, 64'h0D04_0D03_0D02_0D01, 1'b0);
    repeat (4) tick();
    drive(1'b1, 64'h0E04_0E03_0E02_0E01, 1'b1); tick();
    drive(1'b0, '0, 1'b0);
    repeat (5) tick();

    // Bubble inside a burst
    drive(1'b1, 64'h1111_2222_3333_4444, 1'b0); tick();
    drive(1'b0, '0, 1'b0); tick();
    drive(1'b1, 64'h5555_6666_7777_8888, 1'b1); tick();
    drive(1'b0, '0, 1'b0);
    repeat (5) tick();

    // Reset during FLUSH, then a fresh single vector
    drive(1'b1, 64'hFFFF_EEEE_DDDD_CCCC, 1'b1); tick();
    drive(1'b0, '0, 1'b0); tick();
    do_reset();
    drive(1'b1, {16'd4, 16'd3, 16'd2, 16'd1}, 1'b1); tick();
    drive(1'b0, '0, 1'b0);
    repeat (5) tick();

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), {$urandom, $urandom}, $urandom_range(0, 3) == 0);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    repeat (6) tick();

    // COLS=1 build
    s1_valid = 1'b1;
    s1_data  = 16'd7;
    s1_last  = 1'b1;
    @(posedge clk);
    #1;
    s1_valid = 1'b0;
    s1_last  = 1'b0;
    check("c1_top_out",   top_out1,   16'd7);
    check("c1_col_valid", col_valid1, 1'b1);
    check("c1_done",      done1,      1'b1);
    check("c1_s_ready",   s1_ready,   1'b1);
    check("c1_busy",      busy1,      1'b0);
    check("c1_vec_count", vec_count1, 16'd1);
    @(posedge clk);
    #1;
    check("c1_done_end",  done1,      1'b0);
    check("c1_top_end",   top_out1,   '0);
    check("c1_valid_end", col_valid1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
